// File: rtl/chisq_pkg.sv
// Shared types and width helpers for the chi-square sum-of-squares unit.
package chisq_pkg;

    // Control states of the channel issue sequencer.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } chisq_state_e;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Channel index width; never narrower than one bit.
    function automatic int idx_w(input int nchi);
        return (clog2(nchi) < 1) ? 1 : clog2(nchi);
    endfunction

    // Width of an unsigned square of a residual.
    function automatic int sq_w(input int pbits);
        return 2 * pbits;
    endfunction

endpackage

// File: rtl/chisq_macc.sv
// Squaring and accumulate back end: S2 squares one residual per cycle,
// S3 accumulates a vector with sticky overflow and saturates the result.
module chisq_macc
    import chisq_pkg::*;
#(
    parameter int PARAMETERBITS = 14,
    parameter int CHISQBITS     = 32,
    parameter int SIGNED        = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [PARAMETERBITS-1:0] operand,
    input  logic                     load,
    input  logic                     last,
    input  logic                     valid_in,
    output logic [CHISQBITS-1:0]     result,
    output logic                     overflow,
    output logic                     valid_out
);

    localparam int SQW = sq_w(PARAMETERBITS);
    localparam int AW  = CHISQBITS + 1;
    // Adder width covers squares wider than the accumulator (small CHISQBITS).
    localparam int WW  = ((CHISQBITS > SQW) ? CHISQBITS : SQW) + 1;

    // Magnitude squared; the most negative code maps to 2^(2*PARAMETERBITS-2).
    function automatic logic [SQW-1:0] square_op(input logic [PARAMETERBITS-1:0] v);
        logic signed [PARAMETERBITS-1:0] sv;
        logic        [PARAMETERBITS-1:0] mag;
        sv = $signed(v);
        if (SIGNED != 0 && sv < 0) begin
            mag = $unsigned(-sv);
        end else begin
            mag = v;
        end
        return SQW'(mag) * SQW'(mag);
    endfunction

    // All ones once the sticky overflow is set.
    function automatic logic [CHISQBITS-1:0] saturate(input logic [CHISQBITS-1:0] acc,
                                                     input logic ovf);
        return ovf ? {CHISQBITS{1'b1}} : acc;
    endfunction

    logic [SQW-1:0]       sq_p2_q, sq_p2_d;
    logic                 vld_p2_q, vld_p2_d;
    logic                 load_p2_q, load_p2_d;
    logic                 last_p2_q, last_p2_d;
    logic [AW-1:0]        acc_p3_q, acc_p3_d;
    logic                 ovf_p3_q, ovf_p3_d;
    logic [CHISQBITS-1:0] result_q, result_d;
    logic                 overflow_q, overflow_d;
    logic                 valid_q, valid_d;
    logic [WW-1:0]        base_c, sum_c;
    logic                 ovf_new_c;

    // S2: square the selected residual, carry its sideband along.
    always_comb begin
        sq_p2_d   = square_op(operand);
        vld_p2_d  = valid_in;
        load_p2_d = load;
        last_p2_d = last;
    end

    // S3: first element loads, later ones add; last element updates the output.
    always_comb begin
        base_c     = load_p2_q ? '0 : WW'(acc_p3_q);
        sum_c      = base_c + WW'(sq_p2_q);
        ovf_new_c  = (load_p2_q ? 1'b0 : ovf_p3_q) | (|(sum_c >> CHISQBITS));
        acc_p3_d   = acc_p3_q;
        ovf_p3_d   = ovf_p3_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        valid_d    = vld_p2_q & last_p2_q;
        if (vld_p2_q) begin
            acc_p3_d = sum_c[AW-1:0];
            ovf_p3_d = ovf_new_c;
            if (last_p2_q) begin
                result_d   = saturate(sum_c[CHISQBITS-1:0], ovf_new_c);
                overflow_d = ovf_new_c;
            end
        end
    end

    // Control and visible outputs: cleared by reset so in-flight work is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p2_q   <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            vld_p2_q   <= vld_p2_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    // Datapath registers: qualified by the valid bits, no reset needed.
    always_ff @(posedge clock) begin
        sq_p2_q   <= sq_p2_d;
        load_p2_q <= load_p2_d;
        last_p2_q <= last_p2_d;
        acc_p3_q  <= acc_p3_d;
        ovf_p3_q  <= ovf_p3_d;
    end

    assign result    = result_q;
    assign overflow  = overflow_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/chisq_unit_n.sv
// NCHI-channel chi-square unit: captures a residual vector, serialises the
// channels through one square/accumulate path and reports a saturating sum.
module chisq_unit_n
    import chisq_pkg::*;
#(
    parameter int PARAMETERBITS = 14,
    parameter int CHISQBITS     = 32,
    parameter int NCHI          = 6,
    parameter int SIGNED        = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NCHI*PARAMETERBITS-1:0] chi,
    input  logic [NCHI-1:0]               chi_mask,
    input  logic                          dv,
    output logic                          ready,
    output logic [CHISQBITS-1:0]          chisq,
    output logic                          chisq_valid,
    output logic                          overflow,
    output logic                          dv_drop
);

    localparam int              IW       = idx_w(NCHI);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NCHI - 1);

    chisq_state_e                  state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic                          ready_c, issue_c, accept_c;
    logic [NCHI*PARAMETERBITS-1:0] bank_q, bank_d;
    logic [NCHI-1:0]               mask_bank_q, mask_bank_d;
    logic [PARAMETERBITS-1:0]      sel_c;
    logic                          sel_en_c;
    logic [PARAMETERBITS-1:0]      mux_p1_q, mux_p1_d;
    logic                          vld_p1_q, vld_p1_d;
    logic                          load_p1_q, load_p1_d;
    logic                          last_p1_q, last_p1_d;
    logic                          dv_drop_q, dv_drop_d;

    // Issue sequencer: one channel per cycle, reopens for a new vector on the last one.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ready_c  = 1'b0;
        issue_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (dv) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                end
            end
            ST_ISSUE: begin
                issue_c = 1'b1;
                if (idx_q == LAST_IDX) begin
                    ready_c = 1'b1;
                    idx_d   = '0;
                    if (!dv) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        accept_c  = dv & ready_c;
        dv_drop_d = dv & ~ready_c;
    end

    // Holding bank load and S1 channel select; a bank write and the last
    // read share an edge, so the read still sees the previous vector.
    always_comb begin
        bank_d      = accept_c ? chi : bank_q;
        mask_bank_d = accept_c ? chi_mask : mask_bank_q;
        sel_c       = '0;
        sel_en_c    = 1'b0;
        for (int k = 0; k < NCHI; k++) begin
            if (idx_q == IW'(k)) begin
                sel_c    = bank_q[k*PARAMETERBITS +: PARAMETERBITS];
                sel_en_c = mask_bank_q[k];
            end
        end
        mux_p1_d  = sel_en_c ? sel_c : '0;
        vld_p1_d  = issue_c;
        load_p1_d = (idx_q == '0);
        last_p1_d = (idx_q == LAST_IDX);
    end

    // Control state: FSM, index, S1 valid and the drop pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            vld_p1_q  <= 1'b0;
            dv_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vld_p1_q  <= vld_p1_d;
            dv_drop_q <= dv_drop_d;
        end
    end

    // Data registers: holding bank and S1 operand with its sideband.
    always_ff @(posedge clock) begin
        bank_q      <= bank_d;
        mask_bank_q <= mask_bank_d;
        mux_p1_q    <= mux_p1_d;
        load_p1_q   <= load_p1_d;
        last_p1_q   <= last_p1_d;
    end

    chisq_macc #(
        .PARAMETERBITS (PARAMETERBITS),
        .CHISQBITS     (CHISQBITS),
        .SIGNED        (SIGNED)
    ) u_macc (
        .clock     (clock),
        .reset     (reset),
        .operand   (mux_p1_q),
        .load      (load_p1_q),
        .last      (last_p1_q),
        .valid_in  (vld_p1_q),
        .result    (chisq),
        .overflow  (overflow),
        .valid_out (chisq_valid)
    );

    assign ready   = ready_c;
    assign dv_drop = dv_drop_q;

endmodule
